// File: rtl/bakery_pkg.sv
// Shared types and helpers for the bakery ticket-lock arbiter.
package bakery_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CRIT = 2'd2
  } req_state;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } arb_state;

  // Larger of two tickets; callers widen tickets to 32 bits before folding.
  function automatic int unsigned tk_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bakery_pick.sv
// Combinational winner selection: smallest nonzero ticket among waiting
// requesters, lowest index on equal tickets.
module bakery_pick
  import bakery_pkg::*;
#(
  parameter int TKMSB  = 3,
  parameter int HIPROC = 3,
  parameter int SELMSB = 1
) (
  input  logic [(HIPROC+1)*(TKMSB+1)-1:0] tickets,
  input  logic [HIPROC:0]                 wait_mask,
  output logic                            valid,
  output logic [SELMSB:0]                 index
);

  localparam int TW = TKMSB + 1;
  localparam int SW = SELMSB + 1;

  logic [TKMSB:0] best;
  logic [TKMSB:0] tk;

  // Ascending scan with strict less-than keeps the lowest index on ties.
  always_comb begin
    valid = 1'b0;
    index = '0;
    best  = '0;
    tk    = '0;
    for (int i = 0; i <= HIPROC; i++) begin
      tk = tickets[i*TW +: TW];
      if (wait_mask[i] && (tk != '0) && (!valid || (tk < best))) begin
        valid = 1'b1;
        index = SW'(i);
        best  = tk;
      end
    end
  end

endmodule

// File: rtl/bakery_arbiter.sv
// Bakery-ordered ticket lock guarding one shared resource. Tickets saturate
// at all ones instead of wrapping, so ordering degrades to index order but
// mutual exclusion is never lost.
module bakery_arbiter
  import bakery_pkg::*;
#(
  parameter int TKMSB  = 3,
  parameter int HIPROC = 3,
  parameter int SELMSB = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [HIPROC:0]   req,
  input  logic [HIPROC:0]   rel,
  output logic [HIPROC:0]   grant,
  output logic [SELMSB:0]   owner,
  output logic              busy,
  output logic              tk_sat
);

  localparam int          TW      = TKMSB + 1;
  localparam int          SW      = SELMSB + 1;
  localparam int unsigned TK_ALL1 = 32'((1 << TW) - 1);

  req_state       st_q [HIPROC:0];
  req_state       st_d [HIPROC:0];
  logic [TKMSB:0] tk_q [HIPROC:0];
  logic [TKMSB:0] tk_d [HIPROC:0];
  arb_state       arb_q, arb_d;
  logic [HIPROC:0] grant_q, grant_d;
  logic [SELMSB:0] owner_q, owner_d;
  logic            tksat_q, tksat_d;

  logic [(HIPROC+1)*TW-1:0] tk_flat;
  logic [HIPROC:0]          wait_mask;
  logic                     pick_vld;
  logic [SELMSB:0]          pick_idx;
  logic                     do_grant;
  int unsigned              max_all;
  logic                     tk_full;
  logic [TKMSB:0]           tk_new;

  // Flatten registered tickets and the WAIT mask for the picker.
  always_comb begin
    tk_flat   = '0;
    wait_mask = '0;
    for (int i = 0; i <= HIPROC; i++) begin
      tk_flat[i*TW +: TW] = tk_q[i];
      wait_mask[i]        = (st_q[i] == WAIT);
    end
  end

  bakery_pick #(
    .TKMSB (TKMSB),
    .HIPROC(HIPROC),
    .SELMSB(SELMSB)
  ) u_pick (
    .tickets  (tk_flat),
    .wait_mask(wait_mask),
    .valid    (pick_vld),
    .index    (pick_idx)
  );

  // Ticket for newcomers: max of registered tickets plus one, held at all ones.
  always_comb begin
    max_all = 0;
    for (int i = 0; i <= HIPROC; i++) begin
      max_all = tk_max(max_all, 32'(tk_q[i]));
    end
  end

  assign tk_full = (max_all == TK_ALL1);
  assign tk_new  = tk_full ? TW'(max_all) : TW'(max_all + 32'd1);

  // A winner that drops req in the same cycle withdraws and no grant is made.
  assign do_grant = (arb_q == FREE) && pick_vld && req[pick_idx];

  // State register for the arbiter, requesters, tickets and grant outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      arb_q   <= FREE;
      grant_q <= '0;
      owner_q <= '0;
      tksat_q <= 1'b0;
      for (int i = 0; i <= HIPROC; i++) begin
        st_q[i] <= IDLE;
        tk_q[i] <= '0;
      end
    end else begin
      arb_q   <= arb_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      tksat_q <= tksat_d;
      for (int i = 0; i <= HIPROC; i++) begin
        st_q[i] <= st_d[i];
        tk_q[i] <= tk_d[i];
      end
    end
  end

  // Arbiter next state: FREE grants the picked waiter, BUSY waits for the owner's release.
  always_comb begin
    arb_d = arb_q;
    case (arb_q)
      FREE:    if (do_grant) arb_d = BUSY;
      BUSY:    if (rel[owner_q]) arb_d = FREE;
      default: arb_d = FREE;
    endcase
  end

  // Per-requester next state, tickets, grant vector and saturation flag.
  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    tksat_d = tksat_q;
    for (int i = 0; i <= HIPROC; i++) begin
      st_d[i] = st_q[i];
      tk_d[i] = tk_q[i];
      case (st_q[i])
        IDLE: begin
          if (req[i]) begin
            st_d[i] = WAIT;
            tk_d[i] = tk_new;
            if (tk_full) tksat_d = 1'b1;
          end
        end
        WAIT: begin
          if (!req[i]) begin
            st_d[i] = IDLE;
            tk_d[i] = '0;
          end else if (do_grant && (pick_idx == SW'(i))) begin
            st_d[i]    = CRIT;
            grant_d[i] = 1'b1;
            owner_d    = SW'(i);
          end
        end
        CRIT: begin
          if (rel[i]) begin
            st_d[i]    = IDLE;
            tk_d[i]    = '0;
            grant_d[i] = 1'b0;
            owner_d    = '0;
          end
        end
        default: begin
          st_d[i] = IDLE;
          tk_d[i] = '0;
        end
      endcase
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    grant  = grant_q;
    owner  = owner_q;
    busy   = (arb_q == BUSY);
    tk_sat = tksat_q;
  end

endmodule

// File: tb/tb_bakery_arbiter.sv
// Bench for bakery_arbiter: two instances (4-bit and 2-bit tickets) share
// stimulus and are compared every cycle against a ticket-queue model.
module tb_bakery_arbiter;

  localparam int NP = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req, rel;
  logic [3:0] grant_a, grant_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b, sat_a, sat_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: ticket per requester (0 = none), waiting flag, owner (-1 = none).
  int m_tk   [2][NP];
  bit m_wait [2][NP];
  int m_own  [2];
  bit m_sat  [2];

  always #5 clock = ~clock;

  bakery_arbiter #(.TKMSB(3), .HIPROC(3), .SELMSB(1)) dut_a (
    .clock(clock), .reset(reset), .req(req), .rel(rel),
    .grant(grant_a), .owner(owner_a), .busy(busy_a), .tk_sat(sat_a)
  );

  bakery_arbiter #(.TKMSB(1), .HIPROC(3), .SELMSB(1)) dut_b (
    .clock(clock), .reset(reset), .req(req), .rel(rel),
    .grant(grant_b), .owner(owner_b), .busy(busy_b), .tk_sat(sat_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the bakery rules applied to model instance k.
  task automatic model_step(input int k, input int tkmax);
    int maxt, newt, win, key, bestkey;
    if (reset) begin
      for (int i = 0; i < NP; i++) begin
        m_tk[k][i]   = 0;
        m_wait[k][i] = 1'b0;
      end
      m_own[k] = -1;
      m_sat[k] = 1'b0;
      return;
    end
    maxt = 0;
    for (int i = 0; i < NP; i++) if (m_tk[k][i] > maxt) maxt = m_tk[k][i];
    newt = (maxt == tkmax) ? maxt : maxt + 1;
    win = -1;
    bestkey = 0;
    if (m_own[k] < 0) begin
      for (int i = 0; i < NP; i++) begin
        if (m_wait[k][i]) begin
          key = m_tk[k][i] * NP + i;
          if (win < 0 || key < bestkey) begin
            win = i;
            bestkey = key;
          end
        end
      end
    end
    if (win >= 0 && !req[win]) win = -1;
    for (int i = 0; i < NP; i++) begin
      if (m_tk[k][i] == 0) begin
        if (req[i]) begin
          m_tk[k][i]   = newt;
          m_wait[k][i] = 1'b1;
          if (maxt == tkmax) m_sat[k] = 1'b1;
        end
      end else if (m_wait[k][i]) begin
        if (!req[i]) begin
          m_tk[k][i]   = 0;
          m_wait[k][i] = 1'b0;
        end else if (i == win) begin
          m_wait[k][i] = 1'b0;
          m_own[k]     = i;
        end
      end else if (rel[i]) begin
        m_tk[k][i] = 0;
        m_own[k]   = -1;
      end
    end
  endtask

  function automatic logic [3:0] exp_grant(input int k);
    return (m_own[k] >= 0) ? 4'(1 << m_own[k]) : 4'b0;
  endfunction

  function automatic logic [1:0] exp_owner(input int k);
    return (m_own[k] >= 0) ? 2'(m_own[k]) : 2'b0;
  endfunction

  task automatic check_all();
    check_eq("grant_a", 32'(grant_a), 32'(exp_grant(0)));
    check_eq("owner_a", 32'(owner_a), 32'(exp_owner(0)));
    check_eq("busy_a",  32'(busy_a),  32'(m_own[0] >= 0));
    check_eq("tksat_a", 32'(sat_a),   32'(m_sat[0]));
    check_eq("grant_b", 32'(grant_b), 32'(exp_grant(1)));
    check_eq("owner_b", 32'(owner_b), 32'(exp_owner(1)));
    check_eq("busy_b",  32'(busy_b),  32'(m_own[1] >= 0));
    check_eq("tksat_b", 32'(sat_b),   32'(m_sat[1]));
    check_eq("onehot_a", 32'($onehot0(grant_a)), 32'd1);
    check_eq("onehot_b", 32'($onehot0(grant_b)), 32'd1);
    check_eq("busyor_a", 32'(busy_a), 32'(|grant_a));
    check_eq("busyor_b", 32'(busy_b), 32'(|grant_b));
    for (int i = 0; i < NP; i++) begin
      check_eq($sformatf("tk_a[%0d]", i), 32'(dut_a.tk_q[i]), 32'(m_tk[0][i]));
      check_eq($sformatf("tk_b[%0d]", i), 32'(dut_b.tk_q[i]), 32'(m_tk[1][i]));
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step(0, 15);
    model_step(1, 3);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    rel = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    rel = '0;
    step();
    step();
    check_eq("rst_grant", 32'(grant_a), 32'd0);
    check_eq("rst_busy",  32'(busy_a),  32'd0);
    reset = 1'b0;

    // Single request from requester 2.
    req = 4'b0100; step();
    check_eq("single_tk2", 32'(dut_a.tk_q[2]), 32'd1);
    check_eq("single_nogrant", 32'(grant_a), 32'd0);
    step();
    check_eq("single_grant", 32'(grant_a), 32'b0100);
    check_eq("single_owner", 32'(owner_a), 32'd2);
    step();
    rel = 4'b0100; req = 4'b0000; step();
    check_eq("single_rel_grant", 32'(grant_a), 32'd0);
    check_eq("single_rel_busy",  32'(busy_a),  32'd0);
    rel = '0; step();

    // Simultaneous tie: 1 and 3 both get ticket 1, lower index wins.
    req = 4'b1010; step();
    check_eq("tie_tk1", 32'(dut_a.tk_q[1]), 32'd1);
    check_eq("tie_tk3", 32'(dut_a.tk_q[3]), 32'd1);
    step();
    check_eq("tie_grant1", 32'(grant_a), 32'b0010);
    rel = 4'b0010; req = 4'b1000; step();
    check_eq("tie_gap", 32'(grant_a), 32'd0);
    rel = '0; step();
    check_eq("tie_grant3", 32'(grant_a), 32'b1000);
    rel = 4'b1000; req = '0; step();
    rel = '0; step();

    // FIFO order 0, 3, 1.
    req = 4'b0001; step();
    req = 4'b1001; step();
    req = 4'b1011; step();
    check_eq("fifo_tk0", 32'(dut_a.tk_q[0]), 32'd1);
    check_eq("fifo_tk3", 32'(dut_a.tk_q[3]), 32'd2);
    check_eq("fifo_tk1", 32'(dut_a.tk_q[1]), 32'd3);
    check_eq("fifo_g0",  32'(grant_a), 32'b0001);
    rel = 4'b0001; req = 4'b1010; step();
    rel = '0; step();
    check_eq("fifo_g3", 32'(grant_a), 32'b1000);
    rel = 4'b1000; req = 4'b0010; step();
    rel = '0; step();
    check_eq("fifo_g1", 32'(grant_a), 32'b0010);
    rel = 4'b0010; req = '0; step();
    rel = '0; step();

    // Withdraw: 2 waits behind 0, drops req, 3 is served instead.
    req = 4'b0001; step();
    req = 4'b0101; step();
    req = 4'b1101; step();
    check_eq("wd_tk2", 32'(dut_a.tk_q[2]), 32'd2);
    req = 4'b1001; step();
    check_eq("wd_tk2_zero", 32'(dut_a.tk_q[2]), 32'd0);
    rel = 4'b0001; req = 4'b1000; step();
    rel = '0; step();
    check_eq("wd_g3", 32'(grant_a), 32'b1000);
    rel = 4'b1000; req = '0; step();
    rel = '0; step();

    // Saturation: 0 holds the grant while 1 and 2 keep re-ticketing.
    do_reset();
    req = 4'b0001; step(); step();
    for (int j = 0; j < 16; j++) begin
      req = 4'b0111; step();
      req = (j % 2 == 0) ? 4'b0101 : 4'b0011; step();
    end
    req = 4'b0111; step();
    check_eq("sat_a", 32'(sat_a), 32'd1);
    check_eq("sat_b", 32'(sat_b), 32'd1);
    check_eq("sat_tk_b1", 32'(dut_b.tk_q[1]), 32'd3);
    check_eq("sat_tk_b2", 32'(dut_b.tk_q[2]), 32'd3);
    rel = 4'b0001; req = 4'b0110; step();
    rel = '0; step();
    check_eq("sat_tie_b", 32'(grant_b), 32'b0010);

    // Reset while 1 owns and 0, 2 wait; held reqs re-ticket from 1.
    do_reset();
    req = 4'b0010; step(); step();
    req = 4'b0111; step();
    check_eq("rm_owner", 32'(owner_a), 32'd1);
    reset = 1'b1; step();
    check_eq("rm_grant", 32'(grant_a), 32'd0);
    check_eq("rm_busy",  32'(busy_a),  32'd0);
    check_eq("rm_sat",   32'(sat_a),   32'd0);
    check_eq("rm_tk1",   32'(dut_a.tk_q[1]), 32'd0);
    reset = 1'b0; step();
    check_eq("rm_retk0", 32'(dut_a.tk_q[0]), 32'd1);
    check_eq("rm_retk2", 32'(dut_a.tk_q[2]), 32'd1);
    step();
    check_eq("rm_regrant", 32'(grant_a), 32'b0001);

    // Random churn of requests, releases and rare resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(99) < 15) req[i] = ~req[i];
      end
      rel   = 4'($urandom) & 4'($urandom);
      reset = ($urandom_range(499) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
